// File: rtl/ntt_pkg.sv
// Shared constants, FSM state codes and butterfly address helper for the NTT
// memory controller.
package ntt_pkg;

  localparam int Q          = 3329;
  localparam int ADW_DEF    = 5;
  localparam int BF_LAT_DEF = 3;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef struct packed {
    logic [15:0] addr_a;
    logic [15:0] addr_b;
    logic [15:0] tw_idx;
  } bf_addr_t;

  // Butterfly j of stage s: len = N>>(s+1), grp = j/len, k = j%len.
  function automatic bf_addr_t bf_addr(input int adw, input int s, input int j);
    int sh;
    int len;
    int grp;
    int a;
    bf_addr_t r;
    sh       = adw - 1 - s;
    len      = 1 << sh;
    grp      = j >> sh;
    a        = (grp << (sh + 1)) + (j & (len - 1));
    r.addr_a = 16'(a);
    r.addr_b = 16'(a + len);
    r.tw_idx = 16'((1 << s) + grp);
    return r;
  endfunction

endpackage

// File: rtl/ntt_addr_dly.sv
// Shift-register delay line with asynchronous clear; carries the
// {valid, addr_a, addr_b} write tags from read issue to write-back.
module ntt_addr_dly #(
  parameter int W     = 11,
  parameter int DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [DEPTH-1:0][W-1:0] sr_q;
  logic [DEPTH-1:0][W-1:0] sr_d;

  // Next shift-register contents.
  always_comb begin
    sr_d[0] = d_i;
    for (int i = 1; i < DEPTH; i++) begin
      sr_d[i] = sr_q[i-1];
    end
  end

  // Shift-register flops.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign q_o = sr_q[DEPTH-1];

endmodule

// File: rtl/ntt_mem_ctrl.sv
// Read/write address sequencer for the in-place Cooley-Tukey NTT over a
// 2-read/2-write coefficient RAM.
module ntt_mem_ctrl
  import ntt_pkg::*;
#(
  parameter  int ADW    = ADW_DEF,
  parameter  int BF_LAT = BF_LAT_DEF,
  localparam int SW     = (ADW > 1) ? $clog2(ADW) : 1
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           start_i,
  output logic           busy_o,
  output logic           done_o,
  output logic [ADW-1:0] addrr_a_o,
  output logic [ADW-1:0] addrr_b_o,
  output logic           bf_valid_o,
  output logic [ADW-1:0] tw_idx_o,
  output logic [SW-1:0]  stage_o,
  output logic           we_o,
  output logic [ADW-1:0] addrw_a_o,
  output logic [ADW-1:0] addrw_b_o
);

  localparam int DW = 2 * ADW + 1;
  localparam int CW = $clog2(BF_LAT + 1);
  localparam logic [ADW-1:0] J_LAST = ADW'(2 ** (ADW - 1) - 1);
  localparam logic [SW-1:0]  S_LAST = SW'(ADW - 1);
  localparam logic [CW-1:0]  D_LAST = CW'(BF_LAT);

  logic [1:0]     state_q, state_d;
  logic [SW-1:0]  stage_q, stage_d;
  logic [ADW-1:0] j_q, j_d;
  logic [CW-1:0]  dcnt_q, dcnt_d;
  logic           iss_q, iss_d;
  logic [ADW-1:0] ra_q, ra_d, rb_q, rb_d, twi_q, twi_d;
  logic [SW-1:0]  stgi_q, stgi_d, stg_q, stg_d;
  logic           bfv_q, bfv_d, busy_q, busy_d, done_q, done_d;
  logic [ADW-1:0] tw_q, tw_d;
  logic [DW-1:0]  wr_s;
  bf_addr_t       bf_s;
  logic           unused_s;

  assign bf_s     = bf_addr(ADW, int'(stage_q), int'(j_q));
  assign unused_s = ^bf_s;

  // Sequencer next state plus the read-issue and operand-valid pipeline.
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    j_d     = j_q;
    dcnt_d  = dcnt_q;
    iss_d   = 1'b0;
    ra_d    = '0;
    rb_d    = '0;
    twi_d   = '0;
    stgi_d  = '0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_ISSUE;
          stage_d = '0;
          j_d     = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        iss_d  = 1'b1;
        ra_d   = bf_s.addr_a[ADW-1:0];
        rb_d   = bf_s.addr_b[ADW-1:0];
        twi_d  = bf_s.tw_idx[ADW-1:0];
        stgi_d = stage_q;
        if (j_q == J_LAST) begin
          state_d = ST_DRAIN;
          j_d     = '0;
          dcnt_d  = '0;
        end else begin
          j_d = j_q + 1'b1;
        end
      end
      // Hold off reads until every write of this stage has reached the RAM.
      ST_DRAIN: begin
        if (dcnt_q == D_LAST) begin
          if (stage_q == S_LAST) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_ISSUE;
            stage_d = stage_q + 1'b1;
          end
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    bfv_d  = iss_q;
    tw_d   = twi_q;
    stg_d  = stgi_q;
    busy_d = (state_d != ST_IDLE);
    done_d = (state_q == ST_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      stage_q <= '0;
      j_q     <= '0;
      dcnt_q  <= '0;
      iss_q   <= 1'b0;
      ra_q    <= '0;
      rb_q    <= '0;
      twi_q   <= '0;
      stgi_q  <= '0;
      bfv_q   <= 1'b0;
      tw_q    <= '0;
      stg_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      j_q     <= j_d;
      dcnt_q  <= dcnt_d;
      iss_q   <= iss_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      twi_q   <= twi_d;
      stgi_q  <= stgi_d;
      bfv_q   <= bfv_d;
      tw_q    <= tw_d;
      stg_q   <= stg_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  ntt_addr_dly #(
    .W     (DW),
    .DEPTH (BF_LAT + 1)
  ) u_wr_dly (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   ({iss_q, ra_q, rb_q}),
    .q_o   (wr_s)
  );

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign addrr_a_o  = ra_q;
  assign addrr_b_o  = rb_q;
  assign bf_valid_o = bfv_q;
  assign tw_idx_o   = tw_q;
  assign stage_o    = stg_q;
  assign we_o       = wr_s[DW-1];
  assign addrw_a_o  = wr_s[2*ADW-1:ADW];
  assign addrw_b_o  = wr_s[ADW-1:0];

endmodule

// File: tb/tb_ntt_mem_ctrl.sv
// Randomised bench for ntt_mem_ctrl: two instances (BF_LAT=3 and BF_LAT=1)
// compared cycle by cycle against an arithmetic schedule model.
module tb_ntt_mem_ctrl;

  localparam int ADW = 5;
  localparam int N   = 32;

  typedef struct {
    bit v;
    int a;
    int b;
    int tw;
    int s;
  } rd_t;

  logic clk, rst, start, sel;
  logic start0, start1;
  logic busy0, done0, bfv0, we0, busy1, done1, bfv1, we1;
  logic [ADW-1:0] ra0, rb0, tw0, wa0, wb0, ra1, rb1, tw1, wa1, wb1;
  logic [2:0] st0, st1;

  logic o_busy, o_done, o_bfv, o_we;
  logic [ADW-1:0] o_ra, o_rb, o_tw, o_wa, o_wb;
  logic [2:0] o_st;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int pend[N];

  assign start0 = start & ~sel;
  assign start1 = start & sel;

  ntt_mem_ctrl #(.ADW(5), .BF_LAT(3)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .start_i(start0), .busy_o(busy0), .done_o(done0),
    .addrr_a_o(ra0), .addrr_b_o(rb0), .bf_valid_o(bfv0), .tw_idx_o(tw0),
    .stage_o(st0), .we_o(we0), .addrw_a_o(wa0), .addrw_b_o(wb0)
  );

  ntt_mem_ctrl #(.ADW(5), .BF_LAT(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(start1), .busy_o(busy1), .done_o(done1),
    .addrr_a_o(ra1), .addrr_b_o(rb1), .bf_valid_o(bfv1), .tw_idx_o(tw1),
    .stage_o(st1), .we_o(we1), .addrw_a_o(wa1), .addrw_b_o(wb1)
  );

  always_comb begin
    o_busy = sel ? busy1 : busy0;
    o_done = sel ? done1 : done0;
    o_ra   = sel ? ra1   : ra0;
    o_rb   = sel ? rb1   : rb0;
    o_bfv  = sel ? bfv1  : bfv0;
    o_tw   = sel ? tw1   : tw0;
    o_st   = sel ? st1   : st0;
    o_we   = sel ? we1   : we0;
    o_wa   = sel ? wa1   : wa0;
    o_wb   = sel ? wb1   : wb0;
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  // Butterfly whose read addresses are presented in cycle c after start sampling.
  function automatic rd_t rd_at(input int lat, input int c);
    rd_t r;
    int p, s, j, len, grp;
    r = '{0, 0, 0, 0, 0};
    p = N / 2 + lat + 1;
    if (c >= 1 && c <= ADW * p) begin
      s = (c - 1) / p;
      j = (c - 1) % p;
      if (j < N / 2) begin
        len  = N >> (s + 1);
        grp  = j / len;
        r.v  = 1;
        r.a  = grp * 2 * len + (j % len);
        r.b  = r.a + len;
        r.tw = (1 << s) + grp;
        r.s  = s;
      end
    end
    return r;
  endfunction

  task automatic check_quiet(input string tag);
    check_eq({tag, "_busy"}, int'(o_busy), 0);
    check_eq({tag, "_done"}, int'(o_done), 0);
    check_eq({tag, "_we"},   int'(o_we),   0);
    check_eq({tag, "_bfv"},  int'(o_bfv),  0);
    check_eq({tag, "_ra"},   int'(o_ra),   0);
    check_eq({tag, "_wa"},   int'(o_wa),   0);
  endtask

  // mode 0: single start pulse; 1: start held high; 2: random re-pulses while busy.
  task automatic run_ntt(input int lat, input int mode, input bit abort);
    int p, t, ab_c, gap;
    rd_t rv, rb, rw;
    p    = N / 2 + lat + 1;
    t    = ADW * p + 1;
    ab_c = abort ? (2 * p + 1 + int'($urandom_range(0, N / 2 - 1))) : -1;
    gap  = int'($urandom_range(0, 3));
    foreach (pend[i]) pend[i] = 0;
    for (int g = 0; g < gap; g++) begin
      @(posedge clk); #1;
      cyc = -1;
      check_quiet("idle");
    end
    start = 1'b1;
    for (int c = 0; c <= t + 2; c++) begin
      @(posedge clk); #1;
      cyc = c;
      rv  = rd_at(lat, c);
      rb  = rd_at(lat, c - 1);
      rw  = rd_at(lat, c - 1 - lat);
      check_eq("addrr_a",  int'(o_ra),   rv.a);
      check_eq("addrr_b",  int'(o_rb),   rv.b);
      check_eq("bf_valid", int'(o_bfv),  int'(rb.v));
      check_eq("tw_idx",   int'(o_tw),   rb.tw);
      check_eq("stage",    int'(o_st),   rb.s);
      check_eq("we",       int'(o_we),   int'(rw.v));
      check_eq("addrw_a",  int'(o_wa),   rw.a);
      check_eq("addrw_b",  int'(o_wb),   rw.b);
      check_eq("busy",     int'(o_busy), (c < t) ? 1 : 0);
      check_eq("done",     int'(o_done), (c == t) ? 1 : 0);
      // Every read must find its address already written back by the previous stage.
      if (rv.v) begin
        check_eq("hazard_rd_a", pend[o_ra], 0);
        check_eq("hazard_rd_b", pend[o_rb], 0);
        pend[o_ra] = 1;
        pend[o_rb] = 1;
      end
      if (o_we) begin
        check_eq("hazard_wr_a", pend[o_wa], 1);
        check_eq("hazard_wr_b", pend[o_wb], 1);
        pend[o_wa] = 0;
        pend[o_wb] = 0;
      end
      if (c == ab_c) begin
        start = 1'b0;
        #2 rst = 1'b1;
        #1;
        check_quiet("abort");
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      case (mode)
        1:       start = (c < t);
        2:       start = (c < t - 1) && ($urandom_range(0, 3) == 0);
        default: start = 1'b0;
      endcase
    end
    start = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    sel   = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      cyc = -1;
      check_quiet("reset");
      start = (i == 1);
    end
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    run_ntt(3, 0, 1'b0);
    run_ntt(3, 1, 1'b0);
    run_ntt(3, 2, 1'b0);
    run_ntt(3, 0, 1'b1);
    run_ntt(3, int'($urandom_range(0, 2)), 1'b0);
    run_ntt(3, int'($urandom_range(0, 2)), 1'b1);
    run_ntt(3, 0, 1'b0);

    @(negedge clk);
    sel = 1'b1;
    run_ntt(1, 0, 1'b0);
    run_ntt(1, 2, 1'b0);
    run_ntt(1, 1, 1'b1);
    run_ntt(1, int'($urandom_range(0, 2)), 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
